// File: rtl/dynode_event_packer_if.sv
// Dynode record input and 16-bit packet stream, grouped for the event packer.
// slave = packer side, master = integrator/readout side.
interface dynode_event_packer_if;
  logic        ene_load;
  logic [11:0] dyn_energy;
  logic [3:0]  dyn_ingcnt;
  logic [23:0] dyn_evntim;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport slave (
    input  ene_load, dyn_energy, dyn_ingcnt, dyn_evntim, out_ready,
    output out_data, out_valid, out_last
  );

  modport master (
    output ene_load, dyn_energy, dyn_ingcnt, dyn_evntim, out_ready,
    input  out_data, out_valid, out_last
  );
endinterface

// File: rtl/dynode_event_packer.sv
// Buffers dynode energy records in a small FIFO and serialises each one as a
// three-word 16-bit packet on a valid/ready stream.
module dynode_event_packer #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  dynode_event_packer_if.slave  bus,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [15:0]           drop_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned RW    = 48;

  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;

  // Record layout: {seq[47:40], evntim[39:16], ingcnt[15:12], energy[11:0]}
  logic [RW-1:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [15:0]           r_drop;
  logic [7:0]            r_seq;

  state_t                r_state;
  logic [RW-1:0]         r_hold;
  logic                  r_valid;
  logic [15:0]           r_data;
  logic                  r_last;

  logic                  w_full;
  logic                  w_capture;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_accept;
  logic [RW-1:0]         w_rec_in;
  logic [RW-1:0]         w_head;
  state_t                w_state_nxt;
  logic                  w_valid_nxt;
  logic [15:0]           w_data_nxt;
  logic                  w_last_nxt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_capture = bus.ene_load & enable;
  assign w_push    = w_capture & ~w_full;
  assign w_drop    = w_capture & w_full;
  assign w_accept  = r_valid & bus.out_ready;
  assign w_rec_in  = {r_seq, bus.dyn_evntim, bus.dyn_ingcnt, bus.dyn_energy};
  assign w_head    = r_mem[r_rd_ptr];

  // Storage array carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_seq    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        r_seq    <= r_seq + 8'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  // Next state and next registered stream outputs; W0 of a freshly popped
  // record comes straight from the FIFO head, W1/W2 from the hold register.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_W0;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_head[15:0];
          w_last_nxt  = 1'b0;
        end
      end
      S_W0: begin
        if (w_accept) begin
          w_state_nxt = S_W1;
          w_data_nxt  = r_hold[39:24];
        end
      end
      S_W1: begin
        if (w_accept) begin
          w_state_nxt = S_W2;
          w_data_nxt  = {r_hold[23:16], r_hold[47:40]};
          w_last_nxt  = 1'b1;
        end
      end
      S_W2: begin
        if (w_accept) begin
          w_last_nxt = 1'b0;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_W0;
            w_data_nxt  = w_head[15:0];
          end else begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      if (w_pop) begin
        r_hold <= w_head;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign fifo_count    = r_count;
  assign drop_count    = r_drop;

endmodule

// File: tb/tb_dynode_event_packer.sv
// Scoreboard bench for dynode_event_packer: stimulus pushes expected packet
// words, a negedge monitor pops and compares every accepted word.
module tb_dynode_event_packer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;

  dynode_event_packer_if bus ();

  dynode_event_packer #(.DEPTH_LOG2(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_xfer = 0;
  logic [16:0] q[$];
  logic [7:0]  tb_seq = 8'h00;

  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares accepted words and checks stalled words stay put.
  always @(negedge clk) begin
    logic [16:0] exp_w;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.out_data === prev_data && bus.out_last === prev_last)) begin
          errors++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b at %0t",
                   bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last, $time);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_xfer++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h l=%b expected none at %0t",
                   bus.out_data, bus.out_last, $time);
        end else begin
          exp_w = q.pop_front();
          if ({bus.out_last, bus.out_data} !== exp_w) begin
            errors++;
            $display("FAIL word: got l=%b d=%h expected l=%b d=%h at %0t",
                     bus.out_last, bus.out_data, exp_w[16], exp_w[15:0], $time);
          end
        end
      end
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle ene_load strobe; expected words queued only if capture is expected.
  task automatic strobe(input logic [11:0] e, input logic [3:0] c, input logic [23:0] t,
                        input bit exp_acc);
    bus.ene_load   = 1'b1;
    bus.dyn_energy = e;
    bus.dyn_ingcnt = c;
    bus.dyn_evntim = t;
    if (exp_acc) begin
      q.push_back({1'b0, c, e});
      q.push_back({1'b0, t[23:8]});
      q.push_back({1'b1, t[7:0], tb_seq});
      tb_seq = tb_seq + 8'd1;
    end
    tick(1);
    bus.ene_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    tick(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    tb_seq = 8'h00;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    reset          = 1'b1;
    enable         = 1'b1;
    bus.ene_load   = 1'b0;
    bus.dyn_energy = '0;
    bus.dyn_ingcnt = '0;
    bus.dyn_evntim = '0;
    bus.out_ready  = 1'b1;
    tick(3);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last",  32'(bus.out_last),  32'd0);
    chk("rst_data",  32'(bus.out_data),  32'h0000);
    chk("rst_fifo",  32'(fifo_count),    32'd0);
    chk("rst_drop",  32'(drop_count),    32'd0);
    reset = 1'b0;
    tick(1);

    // 1: single record, latency two cycles
    strobe(12'h3A5, 4'd4, 24'h123456, 1'b1);
    chk("t1_valid_n1", 32'(bus.out_valid), 32'd0);
    tick(1);
    chk("t1_valid_n2", 32'(bus.out_valid), 32'd1);
    chk("t1_w0",       32'(bus.out_data),  32'h43A5);
    chk("t1_w0_last",  32'(bus.out_last),  32'd0);
    drain();

    // 2: four back-to-back records, 12 contiguous words
    do_reset();
    tick(1);
    n0 = n_xfer;
    strobe(12'h001, 4'd1, 24'hA00001, 1'b1);
    strobe(12'h002, 4'd2, 24'hA00002, 1'b1);
    strobe(12'h003, 4'd3, 24'hA00003, 1'b1);
    strobe(12'h004, 4'd4, 24'hA00004, 1'b1);
    tick(10);
    chk("t2_contiguous_words", 32'(n_xfer - n0), 32'd12);
    drain();

    // 3: overflow with stalled output
    do_reset();
    tick(1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      strobe(12'(12'h100 + i), 4'(i), 24'(24'hB00000 + i), (i < 9));
    end
    chk("t3_drop",  32'(drop_count),    32'd1);
    chk("t3_fifo",  32'(fifo_count),    32'd8);
    chk("t3_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_w0",    32'(bus.out_data),  32'h0100);
    bus.out_ready = 1'b1;
    drain();
    chk("t3_fifo_after", 32'(fifo_count), 32'd0);
    chk("t3_drop_after", 32'(drop_count), 32'd1);

    // 4: toggling out_ready
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          bus.out_ready = i[0];
          tick(1);
        end
      end
      begin
        strobe(12'hABC, 4'hD, 24'hFEDCBA, 1'b1);
        strobe(12'h5A5, 4'h7, 24'h0F0F0F, 1'b1);
        strobe(12'hFFF, 4'hF, 24'hFFFFFF, 1'b1);
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // 5a: enable low ignores strobes
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe(12'h777, 4'h7, 24'h777777, 1'b0);
    end
    tick(5);
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_fifo",  32'(fifo_count),    32'd0);
    chk("t5_drop",  32'(drop_count),    32'd0);
    enable = 1'b1;

    // 6: reset during W1
    strobe(12'h321, 4'h2, 24'hC0FFEE, 1'b1);
    tick(2);
    chk("t6_in_w1", 32'(bus.out_data), 32'hC0FF);
    reset = 1'b1;
    q.delete();
    tb_seq = 8'h00;
    tick(1);
    reset = 1'b0;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_last",  32'(bus.out_last),  32'd0);
    chk("t6_data",  32'(bus.out_data),  32'h0000);
    chk("t6_fifo",  32'(fifo_count),    32'd0);
    chk("t6_drop",  32'(drop_count),    32'd0);
    strobe(12'h0AA, 4'h1, 24'h123400, 1'b1);
    drain();

    // 5b: sequence wrap, 257 records from seq 00 ends with seq 00
    do_reset();
    tick(1);
    for (int i = 0; i < 257; i++) begin
      strobe(12'(i), 4'(i), 24'(i * 3 + 24'h010000), 1'b1);
      tick(2);
    end
    drain();
    chk("t5_wrap_drop", 32'(drop_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
